// File: rtl/tqv_bridge_pkg.sv
// Shared encodings, FSM state codes and the width-masking helper for the
// SPI to TinyQV peripheral-bus bridge.
package tqv_bridge_pkg;

    localparam logic [1:0] TXN_BYTE = 2'b00;
    localparam logic [1:0] TXN_HALF = 2'b01;
    localparam logic [1:0] TXN_WORD = 2'b10;
    localparam logic [1:0] TXN_IDLE = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_HDR      = 3'd1;
    localparam state_t ST_WDATA    = 3'd2;
    localparam state_t ST_RD_REQ   = 3'd3;
    localparam state_t ST_RD_WAIT  = 3'd4;
    localparam state_t ST_RD_SHIFT = 3'd5;
    localparam state_t ST_DONE     = 3'd6;

    // Data arrives zero-extended to 32 bits; a mask whose range is absent for reg_w is skipped.
    function automatic logic [31:0] mask_data(input logic [31:0] data,
                                              input logic [1:0]  txn,
                                              input int unsigned reg_w);
        logic [31:0] m;
        m = data;
        if (txn == TXN_BYTE && reg_w > 8) begin
            m = m & 32'h0000_00FF;
        end else if (txn == TXN_HALF && reg_w > 16) begin
            m = m & 32'h0000_FFFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-stage flop chain for bringing asynchronous pins into the clk domain.
module synchronizer #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/tqv_spi_bus_bridge.sv
// SPI mode-0 slave that turns framed SPI transactions into TinyQV peripheral
// bus reads/writes across N_SLOTS slots, with a bounded data_ready wait.
module tqv_spi_bus_bridge
    import tqv_bridge_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int REG_W   = 32,
    parameter int N_SLOTS = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_cs_n,
    input  logic                     spi_clk,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic [ADDR_W-1:0]        periph_addr,
    output logic [REG_W-1:0]         periph_wdata,
    output logic [2*N_SLOTS-1:0]     periph_write_n,
    output logic [2*N_SLOTS-1:0]     periph_read_n,
    input  logic [REG_W*N_SLOTS-1:0] periph_rdata,
    input  logic [N_SLOTS-1:0]       periph_ready,
    input  logic [N_SLOTS-1:0]       periph_irq,
    output logic                     irq_out,
    output logic                     err
);

    localparam int SEL_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int HDR_W = 3 + SEL_W + ADDR_W;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = $clog2(((HDR_W > REG_W) ? HDR_W : REG_W) + 1);

    logic cs_s, sclk_s, mosi_s;
    logic cs_q, sclk_q;

    synchronizer #(.STAGES(2), .WIDTH(1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_s));
    synchronizer #(.STAGES(2), .WIDTH(1)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(spi_clk),  .q(sclk_s));
    synchronizer #(.STAGES(2), .WIDTH(1)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));

    // cs_q resets low so the synchronizer coming out of reset can only look like a deselect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q    <= 1'b0;
            sclk_q  <= 1'b0;
            irq_out <= 1'b0;
        end else begin
            cs_q    <= cs_s;
            sclk_q  <= sclk_s;
            irq_out <= |periph_irq;
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = ~cs_s & cs_q;
    assign cs_rise   = cs_s & ~cs_q;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [HDR_W-1:0]     hdr_sr;
    logic [REG_W-1:0]     data_sr;
    logic [1:0]           txn_q;
    logic [SEL_W-1:0]     slot_q;
    logic                 bad_q;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 have_data;
    logic                 start_sent;

    logic [HDR_W-1:0]  hdr_word;
    logic              hdr_rw;
    logic [1:0]        hdr_txn;
    logic [SEL_W-1:0]  hdr_slot;
    logic [ADDR_W-1:0] hdr_addr;
    logic              hdr_bad;
    logic [REG_W-1:0]  wdata_word;

    assign hdr_word   = {hdr_sr[HDR_W-2:0], mosi_s};
    assign hdr_rw     = hdr_word[HDR_W-1];
    assign hdr_txn    = hdr_word[HDR_W-2 -: 2];
    assign hdr_slot   = hdr_word[ADDR_W +: SEL_W];
    assign hdr_addr   = hdr_word[ADDR_W-1:0];
    assign hdr_bad    = (hdr_txn == TXN_IDLE) || ({1'b0, hdr_slot} >= (SEL_W+1)'(N_SLOTS));
    assign wdata_word = {data_sr[REG_W-2:0], mosi_s};

    logic             sel_ready;
    logic [REG_W-1:0] sel_rdata;
    logic [REG_W-1:0] rd_masked;
    logic             rd_tmo;

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (slot_q == SEL_W'(k)) begin
                sel_ready = periph_ready[k];
                sel_rdata = periph_rdata[k*REG_W +: REG_W];
            end
        end
    end

    assign rd_masked = REG_W'(mask_data(32'(sel_rdata), txn_q, REG_W));
    assign rd_tmo    = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Strobes default to idle every cycle so any issued strobe lasts exactly one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            bit_cnt        <= '0;
            hdr_sr         <= '0;
            data_sr        <= '0;
            txn_q          <= TXN_IDLE;
            slot_q         <= '0;
            bad_q          <= 1'b0;
            tmo_cnt        <= '0;
            have_data      <= 1'b0;
            start_sent     <= 1'b0;
            spi_miso       <= 1'b0;
            periph_addr    <= '0;
            periph_wdata   <= '0;
            periph_write_n <= '1;
            periph_read_n  <= '1;
            err            <= 1'b0;
        end else begin
            periph_write_n <= '1;
            periph_read_n  <= '1;
            if (cs_rise) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state   <= ST_HDR;
                            bit_cnt <= '0;
                        end
                    end
                    ST_HDR: begin
                        if (sclk_rise) begin
                            hdr_sr <= hdr_word;
                            if (bit_cnt == CNT_W'(HDR_W - 1)) begin
                                bit_cnt     <= '0;
                                txn_q       <= hdr_txn;
                                slot_q      <= hdr_slot;
                                bad_q       <= hdr_bad;
                                periph_addr <= hdr_addr;
                                tmo_cnt     <= '0;
                                have_data   <= 1'b0;
                                start_sent  <= 1'b0;
                                if (hdr_bad) begin
                                    err <= 1'b1;
                                end
                                if (hdr_rw) begin
                                    state <= ST_WDATA;
                                end else begin
                                    state <= ST_RD_REQ;
                                    for (int k = 0; k < N_SLOTS; k++) begin
                                        if (!hdr_bad && hdr_slot == SEL_W'(k)) begin
                                            periph_read_n[2*k +: 2] <= hdr_txn;
                                        end
                                    end
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise) begin
                            data_sr <= wdata_word;
                            if (bit_cnt == CNT_W'(REG_W - 1)) begin
                                bit_cnt <= '0;
                                state   <= ST_DONE;
                                if (!bad_q) begin
                                    periph_wdata <= REG_W'(mask_data(32'(wdata_word), txn_q, REG_W));
                                    for (int k = 0; k < N_SLOTS; k++) begin
                                        if (slot_q == SEL_W'(k)) begin
                                            periph_write_n[2*k +: 2] <= txn_q;
                                        end
                                    end
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    // RD_REQ is the strobe cycle; ready is already honoured there.
                    ST_RD_REQ, ST_RD_WAIT: begin
                        spi_miso <= 1'b0;
                        if (state == ST_RD_REQ) begin
                            state <= ST_RD_WAIT;
                        end else if (have_data) begin
                            state <= ST_RD_SHIFT;
                        end
                        if (!have_data) begin
                            if (bad_q) begin
                                data_sr   <= '1;
                                have_data <= 1'b1;
                            end else if (sel_ready) begin
                                data_sr   <= rd_masked;
                                err       <= 1'b0;
                                have_data <= 1'b1;
                            end else if (rd_tmo) begin
                                data_sr   <= '1;
                                err       <= 1'b1;
                                have_data <= 1'b1;
                            end else begin
                                tmo_cnt <= tmo_cnt + 1'b1;
                            end
                        end
                    end
                    ST_RD_SHIFT: begin
                        if (sclk_fall) begin
                            if (!start_sent) begin
                                spi_miso   <= 1'b1;
                                start_sent <= 1'b1;
                            end else begin
                                spi_miso <= data_sr[REG_W-1];
                                data_sr  <= {data_sr[REG_W-2:0], 1'b0};
                                if (bit_cnt == CNT_W'(REG_W - 1)) begin
                                    bit_cnt <= '0;
                                    state   <= ST_DONE;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tqv_spi_bus_bridge.sv
// Directed bench for tqv_spi_bus_bridge: bit-banged SPI master plus a slot-0
// ready responder and a passive strobe monitor.
module tb_tqv_spi_bus_bridge;

    localparam int ADDR_W  = 6;
    localparam int REG_W   = 32;
    localparam int N_SLOTS = 2;
    localparam int TIMEOUT = 255;
    localparam int HALF    = 50;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     spi_cs_n = 1'b1;
    logic                     spi_clk = 1'b0;
    logic                     spi_mosi = 1'b0;
    logic                     spi_miso;
    logic [ADDR_W-1:0]        periph_addr;
    logic [REG_W-1:0]         periph_wdata;
    logic [2*N_SLOTS-1:0]     periph_write_n;
    logic [2*N_SLOTS-1:0]     periph_read_n;
    logic [REG_W*N_SLOTS-1:0] periph_rdata = '0;
    logic [N_SLOTS-1:0]       periph_ready = '0;
    logic [N_SLOTS-1:0]       periph_irq = '0;
    logic                     irq_out;
    logic                     err;

    int vectors = 0;
    int miscompares = 0;

    tqv_spi_bus_bridge #(.ADDR_W(ADDR_W), .REG_W(REG_W), .N_SLOTS(N_SLOTS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .periph_addr(periph_addr), .periph_wdata(periph_wdata),
        .periph_write_n(periph_write_n), .periph_read_n(periph_read_n), .periph_rdata(periph_rdata),
        .periph_ready(periph_ready), .periph_irq(periph_irq), .irq_out(irq_out), .err(err)
    );

    always #5 clk = ~clk;

    // Strobe observer: counts strobe cycles per slot and captures the bus at that moment.
    int          wr_cnt0 = 0, wr_cnt1 = 0, rd_cnt0 = 0, rd_cnt1 = 0;
    logic [1:0]  wr_val = 2'b11, rd_val = 2'b11;
    logic [31:0] wr_data = '0;
    logic [5:0]  wr_addr = '0, rd_addr = '0;

    always @(negedge clk) begin
        if (periph_write_n[1:0] != 2'b11) begin wr_cnt0++; wr_val = periph_write_n[1:0]; wr_data = periph_wdata; wr_addr = periph_addr; end
        if (periph_write_n[3:2] != 2'b11) begin wr_cnt1++; wr_val = periph_write_n[3:2]; wr_data = periph_wdata; wr_addr = periph_addr; end
        if (periph_read_n[1:0]  != 2'b11) begin rd_cnt0++; rd_val = periph_read_n[1:0]; rd_addr = periph_addr; end
        if (periph_read_n[3:2]  != 2'b11) begin rd_cnt1++; rd_val = periph_read_n[3:2]; rd_addr = periph_addr; end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_monitor();
        wr_cnt0 = 0; wr_cnt1 = 0; rd_cnt0 = 0; rd_cnt1 = 0;
        wr_val = 2'b11; rd_val = 2'b11;
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        #HALF;
        spi_clk = 1'b1;
        r = spi_miso;
        #HALF;
        spi_clk = 1'b0;
    endtask

    task automatic spi_send(input logic [31:0] v, input int n);
        logic r;
        for (int i = n - 1; i >= 0; i--) spi_bit(v[i], r);
    endtask

    task automatic cs_begin();
        @(negedge clk);
        spi_cs_n = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #HALF;
        spi_cs_n = 1'b1;
        #200;
    endtask

    task automatic spi_read_frame(output logic got, output logic [31:0] data);
        logic r;
        got  = 1'b0;
        data = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            spi_bit(1'b0, r);
            if (r === 1'b1) got = 1'b1;
        end
        if (got) begin
            for (int i = 0; i < 32; i++) begin
                spi_bit(1'b0, r);
                data = {data[30:0], r};
            end
        end
    endtask

    // Slot-0 peripheral: raises ready for one cycle, 'delay' cycles after the strobe cycle.
    task automatic respond(input int delay);
        bit seen;
        seen = 1'b0;
        if (delay >= 0) begin
            for (int i = 0; i < 4000 && !seen; i++) begin
                @(negedge clk);
                if (periph_read_n[1:0] != 2'b11) seen = 1'b1;
            end
            if (seen) begin
                repeat (delay) @(negedge clk);
                periph_ready[0] = 1'b1;
                @(negedge clk);
                periph_ready[0] = 1'b0;
            end
        end
    endtask

    task automatic do_read(input logic [9:0] hdr, input logic [31:0] rdata, input int delay,
                           output logic got, output logic [31:0] data);
        periph_rdata[31:0] = rdata;
        clear_monitor();
        fork
            begin
                cs_begin();
                spi_send({22'b0, hdr}, 10);
                spi_read_frame(got, data);
                cs_end();
            end
            respond(delay);
        join
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #20;
        vectors++; if (periph_write_n !== 4'b1111) begin miscompares++; $display("[TB] FAIL reset_write_n got=%b want=1111", periph_write_n); end
        vectors++; if (periph_read_n !== 4'b1111) begin miscompares++; $display("[TB] FAIL reset_read_n got=%b want=1111", periph_read_n); end
        vectors++; if (periph_addr !== 6'h00) begin miscompares++; $display("[TB] FAIL reset_addr got=%h want=00", periph_addr); end
        vectors++; if (periph_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_wdata got=%h want=0", periph_wdata); end
        vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_miso got=%b want=0", spi_miso); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got=%b want=0", err); end
        vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_irq got=%b want=0", irq_out); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_irq();
        @(negedge clk);
        periph_irq = 2'b10;
        #1;
        vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_before_edge got=%b want=0", irq_out); end
        @(posedge clk); #1;
        vectors++; if (irq_out !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_after_edge got=%b want=1", irq_out); end
        @(negedge clk);
        periph_irq = 2'b00;
        @(posedge clk); #1;
        vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_clear got=%b want=0", irq_out); end
    endtask

    task automatic test_word_write();
        clear_monitor();
        cs_begin();
        spi_send({22'b0, 10'b1_10_1_000101}, 10);
        spi_send(32'hA5A5_1234, 32);
        cs_end();
        vectors++; if (wr_cnt1 !== 1) begin miscompares++; $display("[TB] FAIL wwrite_strobe_cycles got=%0d want=1", wr_cnt1); end
        vectors++; if (wr_val !== 2'b10) begin miscompares++; $display("[TB] FAIL wwrite_txn got=%b want=10", wr_val); end
        vectors++; if (wr_data !== 32'hA5A5_1234) begin miscompares++; $display("[TB] FAIL wwrite_wdata got=%h want=a5a51234", wr_data); end
        vectors++; if (wr_addr !== 6'h05) begin miscompares++; $display("[TB] FAIL wwrite_addr got=%h want=05", wr_addr); end
        vectors++; if (wr_cnt0 + rd_cnt0 + rd_cnt1 !== 0) begin miscompares++; $display("[TB] FAIL wwrite_other_strobes got=%0d want=0", wr_cnt0 + rd_cnt0 + rd_cnt1); end
        vectors++; if (periph_wdata !== 32'hA5A5_1234) begin miscompares++; $display("[TB] FAIL wwrite_wdata_held got=%h want=a5a51234", periph_wdata); end
    endtask

    task automatic test_byte_read();
        logic got; logic [31:0] data;
        do_read(10'b0_00_0_001100, 32'hDEAD_BEEF, 3, got, data);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL bread_start got=%b want=1", got); end
        vectors++; if (data !== 32'h0000_00EF) begin miscompares++; $display("[TB] FAIL bread_data got=%h want=000000ef", data); end
        vectors++; if (rd_cnt0 !== 1 || rd_val !== 2'b00) begin miscompares++; $display("[TB] FAIL bread_strobe got=%0d/%b want=1/00", rd_cnt0, rd_val); end
        vectors++; if (rd_addr !== 6'h0C) begin miscompares++; $display("[TB] FAIL bread_addr got=%h want=0c", rd_addr); end
        vectors++; if (rd_cnt1 !== 0) begin miscompares++; $display("[TB] FAIL bread_slot1_strobe got=%0d want=0", rd_cnt1); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL bread_err got=%b want=0", err); end
    endtask

    task automatic test_half_read();
        logic got; logic [31:0] data;
        do_read(10'b0_01_0_000011, 32'hDEAD_BEEF, 1, got, data);
        vectors++; if (got !== 1'b1 || data !== 32'h0000_BEEF) begin miscompares++; $display("[TB] FAIL hread_data got=%b/%h want=1/0000beef", got, data); end
        vectors++; if (rd_val !== 2'b01) begin miscompares++; $display("[TB] FAIL hread_txn got=%b want=01", rd_val); end
    endtask

    task automatic test_timeout();
        logic got; logic [31:0] data;
        do_read(10'b0_10_0_000001, 32'h1357_9BDF, -1, got, data);
        vectors++; if (got !== 1'b1 || data !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL tmo_data got=%b/%h want=1/ffffffff", got, data); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_err got=%b want=1", err); end
    endtask

    task automatic test_zero_wait_read();
        logic got; logic [31:0] data;
        do_read(10'b0_10_0_000010, 32'h1234_5678, 0, got, data);
        vectors++; if (got !== 1'b1 || data !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL zwread_data got=%b/%h want=1/12345678", got, data); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL zwread_err_clear got=%b want=0", err); end
    endtask

    task automatic test_illegal_write();
        clear_monitor();
        cs_begin();
        spi_send({22'b0, 10'b1_11_0_001010}, 10);
        spi_send(32'hFFFF_0000, 32);
        cs_end();
        vectors++; if (wr_cnt0 + wr_cnt1 + rd_cnt0 + rd_cnt1 !== 0) begin miscompares++; $display("[TB] FAIL illwrite_strobes got=%0d want=0", wr_cnt0 + wr_cnt1 + rd_cnt0 + rd_cnt1); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL illwrite_err got=%b want=1", err); end
    endtask

    task automatic test_illegal_read();
        logic got; logic [31:0] data;
        do_read(10'b0_11_0_000100, 32'h0000_0000, -1, got, data);
        vectors++; if (got !== 1'b1 || data !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL illread_data got=%b/%h want=1/ffffffff", got, data); end
        vectors++; if (rd_cnt0 + rd_cnt1 !== 0) begin miscompares++; $display("[TB] FAIL illread_strobes got=%0d want=0", rd_cnt0 + rd_cnt1); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL illread_err got=%b want=1", err); end
    endtask

    task automatic test_write_abort();
        clear_monitor();
        cs_begin();
        spi_send({22'b0, 10'b1_00_0_010001}, 10);
        spi_send(32'h000A_BCDE, 20);
        cs_end();
        vectors++; if (wr_cnt0 + wr_cnt1 !== 0) begin miscompares++; $display("[TB] FAIL abort_strobes got=%0d want=0", wr_cnt0 + wr_cnt1); end
        clear_monitor();
        cs_begin();
        spi_send({22'b0, 10'b1_00_0_100010}, 10);
        spi_send(32'h1234_5678, 32);
        cs_end();
        vectors++; if (wr_cnt0 !== 1 || wr_val !== 2'b00) begin miscompares++; $display("[TB] FAIL after_abort_strobe got=%0d/%b want=1/00", wr_cnt0, wr_val); end
        vectors++; if (wr_data !== 32'h0000_0078) begin miscompares++; $display("[TB] FAIL after_abort_wdata got=%h want=00000078", wr_data); end
        vectors++; if (wr_addr !== 6'h22) begin miscompares++; $display("[TB] FAIL after_abort_addr got=%h want=22", wr_addr); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL write_keeps_err got=%b want=1", err); end
    endtask

    task automatic test_reset_mid_read();
        periph_irq = 2'b10;
        clear_monitor();
        cs_begin();
        spi_send({22'b0, 10'b0_10_0_111111}, 10);
        #300;
        vectors++; if (rd_cnt0 !== 1 || irq_out !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_state got=%0d/%b want=1/1", rd_cnt0, irq_out); end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++; if (periph_write_n !== 4'b1111 || periph_read_n !== 4'b1111) begin miscompares++; $display("[TB] FAIL async_reset_strobes got=%b/%b want=1111/1111", periph_write_n, periph_read_n); end
        vectors++; if (periph_addr !== 6'h00 || periph_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL async_reset_bus got=%h/%h want=00/00000000", periph_addr, periph_wdata); end
        vectors++; if (err !== 1'b0 || irq_out !== 1'b0 || spi_miso !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_flags got=%b%b%b want=000", err, irq_out, spi_miso); end
        spi_cs_n   = 1'b1;
        periph_irq = 2'b00;
        #50;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        $display("[TB] starting tqv_spi_bus_bridge bench");
        test_reset();
        test_irq();
        test_word_write();
        test_byte_read();
        test_half_read();
        test_timeout();
        test_zero_wait_read();
        test_illegal_write();
        test_illegal_read();
        test_write_abort();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tqv_spi_bus_bridge.md
# tqv_spi_bus_bridge

SPI-slave to TinyQV peripheral-bus bridge that replaces the single-peripheral SPI test harness. It serves N_SLOTS peripherals at parametrised address and data widths. It honours the peripheral `data_ready` handshake with a bounded wait and a sticky timeout flag, and masks read data to the transaction width. It sits between the chip's SPI pins and the peripheral slots, and aggregates their interrupts.

## Interface
- `ADDR_W`, 6: peripheral register address width.
- `REG_W`, 32: data width; legal values are 8, 16 and 32.
- `N_SLOTS`, 2: number of peripheral slots, ≥1.
- `TIMEOUT`, 255: maximum clk cycles to wait for `data_ready` on a read.
- `SEL_W` (localparam): max(1, clog2(N_SLOTS)).
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `spi_cs_n`, `spi_clk`, `spi_mosi` in 1 each: raw, asynchronous pins.
- `spi_miso` out 1: serial read data.
- `periph_addr` out ADDR_W: register address, shared by all slots.
- `periph_wdata` out REG_W: write data, shared by all slots.
- `periph_write_n` out 2*N_SLOTS: per-slot write strobe; 2'b11 = idle, otherwise the txn width.
- `periph_read_n` out 2*N_SLOTS: per-slot read strobe, same encoding.
- `periph_rdata` in REG_W*N_SLOTS: per-slot read data; slot k occupies [k*REG_W +: REG_W].
- `periph_ready` in N_SLOTS: per-slot `data_ready`.
- `periph_irq` in N_SLOTS: per-slot interrupt.
- `irq_out` out 1: registered OR of `periph_irq`.
- `err` out 1: sticky error flag.

## Operation
- SPI runs in mode 0.
- Each input pin passes through a 2-stage synchronizer.
- MOSI is sampled on the synchronized SCLK rising edge; MISO is updated on the falling edge.
- Header is HDR_W = 3+SEL_W+ADDR_W bits, sent MSB-first in this order: `rw` (1 = write), `txn[1:0]`, `slot`, `addr`.
- txn encoding: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- States:
  - IDLE → HDR on CS falling edge.
  - HDR → WDATA if rw = 1, or RD_REQ if rw = 0, once HDR_W bits are in.
  - WDATA → DONE after REG_W bits; the write strobe is issued at that point.
  - RD_REQ → RD_WAIT after one cycle.
  - RD_WAIT → RD_SHIFT on a latched result.
  - RD_SHIFT → DONE after the start bit plus REG_W bits.
  - DONE → IDLE on CS high.
  - Any state → IDLE on CS rising edge. A write that has not completed issues no strobe. An abort in RD_WAIT drops the wait and returns no data.
- Read:
  - The selected slot's `periph_read_n` = txn for exactly one cycle.
  - The timeout counter runs from the strobe cycle.
  - On the first cycle with `periph_ready[slot]` high, the bridge latches masked `periph_rdata[slot]`.
  - Other slots' ready signals are ignored.
- Timeout: when the counter reaches TIMEOUT cycles with no ready, the bridge latches all-ones data and sets `err`.
- Wait-state protocol on MISO:
  - MISO = 0 while in RD_WAIT.
  - After the latch, the next falling edge drives a 1 (start bit).
  - The following REG_W falling edges drive data MSB-first.
  - The master polls for the start bit.
- Masking, applied to both read data and write data:
  - byte: clears bits [REG_W-1:8].
  - half: clears bits [REG_W-1:16].
  - word: passes all bits.
  - Masking is skipped where a range does not exist for the given REG_W.
- Illegal frame (txn = 11, or slot ≥ N_SLOTS):
  - No strobe is issued.
  - `err` is set when the header completes.
  - A read returns the start bit followed by all ones.
- `err` clears only when a read completes without timeout. It is not cleared on writes.

## Timing
- Reset values:
  - All strobes are 1s.
  - `periph_addr` = 0, `periph_wdata` = 0.
  - `spi_miso` = 0, `err` = 0, `irq_out` = 0.
  - State = IDLE, counters = 0.
- Write strobe asserts in the clk cycle after the cycle in which the final data bit is sampled. It lasts 1 cycle.
- `periph_addr`/`periph_wdata` stay stable from the strobe until the next header completes.
- Read strobe asserts in the clk cycle after the final header bit is sampled. `periph_addr` is valid in that cycle.
- Ready in the strobe cycle itself is a 0-wait read and is accepted.
- SCLK must be ≤ clk/4. End-to-end SPI latency, counted from the pins, is 2 clk of synchronizer delay plus 1 clk of edge detection.
- `irq_out` is registered: one cycle behind `periph_irq`.
- Ready and timeout in the same cycle: ready wins, and `err` is not set.

## Structure
- Package `tqv_bridge_pkg` holds:
  - txn encodings TXN_BYTE, TXN_HALF, TXN_WORD, TXN_IDLE;
  - the FSM state enum;
  - a masking function parametrised on REG_W.
- Reuse the existing `synchronizer` (STAGES = 2, WIDTH = 1) three times.
- No other sub-module is needed: the shift register, FSM and timeout counter sit in this module.

## Test plan
- Word write: slot 1, addr 0x05, data 0xA5A5_1234. Required: `periph_write_n[3:2]` = 10 for 1 cycle, `wdata` = 0xA5A5_1234, `addr` = 0x05, slot 0 strobes stay 11.
- Byte read: slot 0, rdata 0xDEADBEEF, ready 3 cycles after the strobe. Required: MISO shows 0s, then the start bit 1, then 0x000000EF; `err` = 0.
- Timeout: slot 0 read, ready held low. Required: after 255 cycles the frame returns a start bit followed by 0xFFFFFFFF; `err` = 1. A subsequent good read clears `err`.
- Illegal frame: txn = 11, rw = 1. Required: no strobe on any slot; `err` = 1.
- Write abort: CS raised after 20 of the 32 data bits. Required: no strobe; the next full frame works normally.
- Interrupts and reset: `periph_irq` = 2'b10 gives `irq_out` = 1 one cycle later. `rst_n` asserted mid-RD_WAIT returns all outputs to their reset values immediately, asynchronously.
